pipe_interlock: RTL
===================

# pipe_interlock

Parametrised hazard controller for the pipelined CPU, successor to the fixed two-stage forwarding/load-use pair. Tracks every in-flight register write from EX through write-back in an internal scoreboard shift register. Generates PC/IF-ID write enables, IF-ID flush, ID-EX bubble and per-operand forwarding selects. Supports configurable forwarding depth and load latency, an external whole-pipe freeze, and optional stall/flush performance counters.

## Interface
- REG_AW, 5: register address width
- FWD_DEPTH, 2: pipeline slots after EX that can forward (slot 1 = EX/MEM … slot FWD_DEPTH = MEM/WB); legal range 2..6
- LOAD_LAT, 1: extra cycles after EX before load data exists; legal range 1..FWD_DEPTH-1
- SEL_W, $clog2(FWD_DEPTH+1): forwarding select width (derived, not overridden)

- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  ID source registers
- id_rs_used, id_rt_used  in  1  source actually read
- id_rd  in  REG_AW  ID destination
- id_wr  in  1  ID instruction writes id_rd
- id_load  in  1  ID instruction is a load
- ex_redirect  in  1  branch/jump resolved taken in EX
- ext_stall  in  1  freeze entire pipe (memory/UART busy)
- pc_write  out  1  PC may update
- ifid_write  out  1  IF/ID may update
- ifid_flush  out  1  IF/ID loads a nop
- idex_bubble  out  1  ID/EX loads a nop
- fwd_a, fwd_b  out  SEL_W  EX operand source: 0 = ID/EX value, k = result in slot k
- stall_cnt, flush_cnt  out  32  present only with PIPE_INTERLOCK_PERF_EN

## Operation
- Scoreboard: slots 0..FWD_DEPTH (slot 0 = EX). Each slot: valid, rd, wr, load; slot 0 also rs, rt, rs_used, rt_used.
- Producer ready slot: 1 for ALU writes, 1+LOAD_LAT for loads.
- Load-use hazard: an ID source (used, nonzero) matches slot k (valid, wr, rd nonzero) with k+1 < ready slot. Any match → hazard.
- Forwarding: for each slot-0 source (used, nonzero), fwd = lowest k in 1..FWD_DEPTH whose slot is valid, wr and rd-matching; 0 if none. Register 0 is never forwarded. The select is purely combinational from the scoreboard.
- Producers that have left slot FWD_DEPTH are in the register file. The register file is write-through, so no slot FWD_DEPTH+1 check is needed.
- Priority, highest first: reset, ext_stall, ex_redirect, hazard.
  - ext_stall: pc_write=0, ifid_write=0, flush=0, bubble=0, scoreboard holds. ex_redirect must be held by its source until the freeze ends.
  - ex_redirect: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. The hazard is ignored because the ID instruction is discarded.
  - hazard: pc_write=0, ifid_write=0, idex_bubble=1.
  - none: pc_write=1, ifid_write=1, flush=0, bubble=0.
- Scoreboard shift when not frozen: slot k ← slot k-1. Slot 0 ← ID fields, with valid = id_valid & ~idex_bubble.

## Timing
- All control outputs are combinational from inputs and scoreboard; no added latency.
- Scoreboard updates on rising clk.
- Load-use stall lasts exactly ready−1−k cycles for a producer first seen in slot k. With defaults, a load in EX plus a dependent instruction in ID gives 1 stall cycle, then fwd = 2.
- Reset values: scoreboard all invalid. pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=0, counters 0.
- Reset mid-stall clears the scoreboard at the next edge; no stale hazard survives.
- ext_stall asserted during a hazard: the hazard reappears unchanged after release.

## Configuration
- PIPE_INTERLOCK_PERF_EN defined:
  - stall_cnt increments every cycle with a hazard stall (not ext_stall).
  - flush_cnt increments every ex_redirect cycle not masked by ext_stall.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: counter ports and logic are absent.

## Structure
- Shared package pipe_pkg holds:
  - the slot record typedef (valid, rd, wr, load)
  - FWD_SEL_NONE = 0
  - a ready-slot function of (load, LOAD_LAT)
- One sub-module, pipe_fwd_match: priority compare of one source against slots 1..FWD_DEPTH, returning a select. It is instantiated twice (fwd_a, fwd_b).

## Test plan
- Defaults; ALU writes $8, next instruction reads $8 in rs → no stall, fwd_a=1; one cycle later an unrelated instruction in EX reading $8 → fwd_a=2.
- Load writes $9, ID reads $9 in rt → 1 cycle with pc_write=0, idex_bubble=1, then fwd_b=2.
- LOAD_LAT=2, FWD_DEPTH=3; load $9 then dependent instruction → 2 stall cycles, then fwd=3.
- Load-use hazard and ex_redirect in the same cycle → ifid_flush=1, idex_bubble=1, pc_write=1; with PIPE_INTERLOCK_PERF_EN, stall_cnt unchanged and flush_cnt +1.
- Writes to $0, and ext_stall held 5 cycles mid-load-use:
  - writes to $0 → never forwarded, never stall
  - ext_stall → outputs frozen with stall asserted, scoreboard unchanged, stall resumes for 1 cycle after release
- Reset asserted during a stall → next cycle all outputs return to reset values and scoreboard is empty.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared scoreboard slot record, forwarding constants and producer ready-slot helper
package pipe_pkg;
  localparam int RD_MAX = 8;
  localparam int FWD_SEL_NONE = 0;
  typedef struct packed {
    logic              valid;
    logic [RD_MAX-1:0] rd;
    logic              wr;
    logic              load;
  } slot_t;
  function automatic int ready_slot(input logic load, input int load_lat);
    return load ? 1 + load_lat : 1;
  endfunction
endpackage

// File: rtl/pipe_fwd_match.sv
// pipe_fwd_match: priority compare of one EX source against slots 1..FWD_DEPTH, lowest slot wins
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic [RD_MAX-1:0] src,
  input  logic              used,
  input  logic [FWD_DEPTH:1] live,
  input  logic [RD_MAX-1:0] rds [1:FWD_DEPTH],
  output logic [SEL_W-1:0]  sel
);
  // scan oldest to youngest so the youngest matching producer is the last one written
  always_comb begin
    sel = SEL_W'(FWD_SEL_NONE);
    for (int k = FWD_DEPTH; k >= 1; k--)
      if (used && src != '0 && live[k] && rds[k] == src) sel = SEL_W'(k);
  end
endmodule

// File: rtl/pipe_interlock.sv
// pipe_interlock: hazard/forwarding controller; stall/flush counters with PIPE_INTERLOCK_PERF_EN
module pipe_interlock
  import pipe_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              ex_redirect,
  input  logic              ext_stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b
`ifdef PIPE_INTERLOCK_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);
  slot_t             sb0;
  slot_t             pipe [1:FWD_DEPTH];
  logic [RD_MAX-1:0] ex_rs, ex_rt;
  logic              ex_rs_used, ex_rt_used;
  logic [RD_MAX-1:0] rs_x, rt_x, rd_x;
  logic              hz, hazard;
  logic [FWD_DEPTH:1] live;
  logic [RD_MAX-1:0] rds [1:FWD_DEPTH];

  assign rs_x = RD_MAX'(id_rs);
  assign rt_x = RD_MAX'(id_rt);
  assign rd_x = RD_MAX'(id_rd);

  // a producer in slot k blocks ID while its result is still too far from existing to forward
  function automatic logic hit(input slot_t s, input int k);
    return s.valid && s.wr && s.rd != '0 && (k + 1 < ready_slot(s.load, LOAD_LAT)) &&
           ((id_rs_used && rs_x != '0 && rs_x == s.rd) || (id_rt_used && rt_x != '0 && rt_x == s.rd));
  endfunction

  // load-use detection across EX and every forwarding slot
  always_comb begin
    hz = hit(sb0, 0);
    for (int k = 1; k <= FWD_DEPTH; k++) hz = hz | hit(pipe[k], k);
  end

  assign hazard      = id_valid & hz;
  assign pc_write    = ~ext_stall & (ex_redirect | ~hazard);
  assign ifid_write  = ~ext_stall & (ex_redirect | ~hazard);
  assign ifid_flush  = ~ext_stall & ex_redirect;
  assign idex_bubble = ~ext_stall & (ex_redirect | hazard);

  // flatten forwarding slots into compare inputs
  always_comb begin
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      live[k] = pipe[k].valid & pipe[k].wr;
      rds[k]  = pipe[k].rd;
    end
  end

  pipe_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_fwd_a (
    .src(ex_rs), .used(sb0.valid & ex_rs_used), .live(live), .rds(rds), .sel(fwd_a)
  );
  pipe_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_fwd_b (
    .src(ex_rt), .used(sb0.valid & ex_rt_used), .live(live), .rds(rds), .sel(fwd_b)
  );

  // scoreboard advances one slot per cycle unless the whole pipe is frozen
  always_ff @(posedge clk) begin
    if (reset) begin
      sb0        <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rs_used <= 1'b0;
      ex_rt_used <= 1'b0;
      for (int k = 1; k <= FWD_DEPTH; k++) pipe[k] <= '0;
    end else if (!ext_stall) begin
      sb0        <= '{valid: id_valid & ~idex_bubble, rd: rd_x, wr: id_wr, load: id_load};
      ex_rs      <= rs_x;
      ex_rt      <= rt_x;
      ex_rs_used <= id_rs_used;
      ex_rt_used <= id_rt_used;
      pipe[1]    <= sb0;
      for (int k = 2; k <= FWD_DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end

`ifdef PIPE_INTERLOCK_PERF_EN
  // count hazard stalls and redirect flushes that actually take effect
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard & ~ext_stall & ~ex_redirect) stall_cnt <= stall_cnt + 32'd1;
      if (ex_redirect & ~ext_stall) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif
endmodule
